// File: rtl/program_loader_pkg.sv
// Shared loader types: FSM state encoding and header size.
// No ports; imported by the interface, assembler and loader top.
package common;

    localparam int LOADER_HDR_BYTES = 4;

    typedef enum logic [1:0] {
        LEN,
        DATA,
        DONE,
        ERROR
    } loader_state_t;

endpackage

// File: rtl/program_loader_if.sv
// Loader bus bundle: UART byte stream and control in, program memory
// port and CPU status out. slave = loader side, master = environment.
interface program_loader_if;

    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        load_req;
    logic [31:0] pc_address;
    logic [31:0] mem_address;
    logic        mem_write_enable;
    logic [31:0] mem_write_data;
    logic        cpu_hold;
    logic        load_done;
    logic        load_error;

    modport slave (
        input  rx_data, rx_valid, load_req, pc_address,
        output mem_address, mem_write_enable, mem_write_data,
        output cpu_hold, load_done, load_error
    );

    modport master (
        output rx_data, rx_valid, load_req, pc_address,
        input  mem_address, mem_write_enable, mem_write_data,
        input  cpu_hold, load_done, load_error
    );

endinterface

// File: rtl/program_loader_word_assembler.sv
// Little-endian byte-to-word assembler (first byte lands in bits 7:0).
// Ports: clk, reset, clear, shift, data in; word, word_done out.
module word_assembler
    import common::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        shift,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic        word_done
);

    logic [31:0] sr_q;
    logic [1:0]  byte_cnt;

    // word is the value the register would hold with the current byte
    // shifted in, so the caller sees a complete word on the 4th byte.
    assign word      = {data, sr_q[31:8]};
    assign word_done = shift
        && (byte_cnt == 2'(LOADER_HDR_BYTES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q     <= '0;
            byte_cnt <= '0;
        end else if (clear) begin
            sr_q     <= '0;
            byte_cnt <= '0;
        end else if (shift) begin
            sr_q     <= word;
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/program_loader.sv
// UART program loader: length header, then words written to memory.
// Ports: clk, reset, bus (program_loader_if.slave).
module program_loader
    import common::*;
#(
    parameter int MEM_WORDS      = 1024,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input logic            clk,
    input logic            reset,
    program_loader_if.slave bus
);

    loader_state_t state_q, state_d;
    logic [29:0]   idx_q, idx_d;
    logic [31:0]   len_q, len_d;
    logic [31:0]   tcnt_q, tcnt_d;
    logic [31:0]   waddr_q, waddr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          we_q, we_d;
    logic          started_q, started_d;
    logic          accept;
    logic          word_done;
    logic [31:0]   word;

    // load_req wins over a byte in the same cycle.
    assign accept = bus.rx_valid && !bus.load_req
        && (state_q == LEN || state_q == DATA);

    word_assembler u_asm (
        .clk       (clk),
        .reset     (reset),
        .clear     (bus.load_req),
        .shift     (accept),
        .data      (bus.rx_data),
        .word      (word),
        .word_done (word_done)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        len_d     = len_q;
        tcnt_d    = tcnt_q;
        started_d = started_q;
        waddr_d   = waddr_q;
        we_d      = 1'b0;
        wdata_d   = '0;
        if (bus.load_req) begin
            state_d   = LEN;
            idx_d     = '0;
            len_d     = '0;
            tcnt_d    = '0;
            started_d = 1'b0;
        end else begin
            unique case (state_q)
                LEN, DATA: begin
                    if (accept) begin
                        tcnt_d    = '0;
                        started_d = 1'b1;
                        if (word_done && state_q == LEN) begin
                            len_d = word;
                            idx_d = '0;
                            if (word == 32'd0)
                                state_d = DONE;
                            else if (word > 32'(MEM_WORDS))
                                state_d = ERROR;
                            else
                                state_d = DATA;
                        end else if (word_done) begin
                            we_d    = 1'b1;
                            wdata_d = word;
                            waddr_d = {idx_q, 2'b00};
                            if ({2'b00, idx_q} == len_q - 32'd1)
                                state_d = DONE;
                            else
                                idx_d = idx_q + 30'd1;
                        end
                    end else if (started_q) begin
                        tcnt_d = tcnt_q + 32'd1;
                        if (tcnt_d == 32'(TIMEOUT_CYCLES))
                            state_d = ERROR;
                    end
                end
                DONE, ERROR: begin
                end
                default: state_d = LEN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= LEN;
            idx_q     <= '0;
            len_q     <= '0;
            tcnt_q    <= '0;
            started_q <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            tcnt_q    <= tcnt_d;
            started_q <= started_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
        end
    end

    // The final write coincides with DONE; the write address must win
    // there or the last word would land at pc_address.
    assign bus.mem_address = we_q ? waddr_q
        : (state_q == DONE) ? bus.pc_address
        : {idx_q, 2'b00};
    assign bus.mem_write_enable = we_q;
    assign bus.mem_write_data   = we_q ? wdata_q : '0;
    assign bus.cpu_hold         = (state_q != DONE);
    assign bus.load_done        = (state_q == DONE);
    assign bus.load_error       = (state_q == ERROR);

endmodule
